md5_result_collector: RTL and testbench

- Synthesizable consumer end of the md5calculator done/md5 result interface; replaces behavioural polling of per-CPU done flags.
- Round-robin scanner visits CPUs, captures each finished hash once, and pulses a per-CPU ack.
- Captured results are pushed as (index, md5) records into a small FIFO and drained through a valid/ready stream.
- Sits between the CPU array and a result sink (UART/log/checker); asserts all_done when every CPU has been collected and drained.

---
 rtl/md5_collect_pkg.sv | 10 +
 rtl/md5_result_fifo.sv | 43 ++++
 rtl/md5_result_collector.sv | 104 ++++++++++
 tb/tb_md5_result_collector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_collect_pkg.sv
// md5_collect_pkg: result record and collector state shared by the collector and its FIFO
package md5_collect_pkg;
  localparam int RES_IDX_W = 10;
  localparam int RES_MD5_W = 128;
  typedef struct packed {
    logic [RES_IDX_W-1:0] idx;
    logic [RES_MD5_W-1:0] md5;
  } result_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
endpackage

// File: rtl/md5_result_fifo.sv
// md5_result_fifo: synchronous FIFO of result records with flush
module md5_result_fifo
  import md5_collect_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  result_t       din,
  output result_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  result_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/md5_result_collector.sv
// md5_result_collector: round-robin capture of per-CPU md5 results into a valid/ready stream
// Optional stall timeout enabled by MD5_COLLECT_TIMEOUT_EN.
module md5_result_collector
  import md5_collect_pkg::*;
#(
  parameter int CPU_COUNT = 1024,
  parameter int HASH_WIDTH = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int IDX_WIDTH = CPU_COUNT > 1 ? $clog2(CPU_COUNT) : 1
)(
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic [CPU_COUNT-1:0]           cpu_done,
  input  logic [CPU_COUNT*HASH_WIDTH-1:0] cpu_md5,
  output logic [CPU_COUNT-1:0]           cpu_ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_WIDTH-1:0]           out_index,
  output logic [HASH_WIDTH-1:0]          out_md5,
  output logic [IDX_WIDTH:0]             collected,
  output logic                           all_done,
  output logic                           timeout
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  state_e state, state_n;
  logic [IDX_WIDTH-1:0] ptr;
  logic [CPU_COUNT-1:0] captured;
  logic hit, push, pop, full, empty;
  logic [FAW:0] count;
  result_t din, head;
  always_comb begin
    hit = state == SCAN && cpu_done[ptr] && !captured[ptr];
    push = hit && !full && !clear;
    pop = out_valid && out_ready;
    din = '{idx: RES_IDX_W'(ptr), md5: RES_MD5_W'(cpu_md5[ptr*HASH_WIDTH +: HASH_WIDTH])};
    state_n = state;
    if (clear) state_n = SCAN;
    else
      case (state)
        IDLE:    state_n = SCAN;
        SCAN:    if (collected == (IDX_WIDTH+1)'(CPU_COUNT)) state_n = DRAIN;
        DRAIN:   if (count == '0) state_n = DONE;
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // A capture blocked by a full FIFO holds the pointer so the CPU is retried next cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr <= '0;
      captured <= '0;
      collected <= '0;
      cpu_ack <= '0;
    end else if (clear) begin
      ptr <= '0;
      captured <= '0;
      collected <= '0;
      cpu_ack <= '0;
    end else begin
      cpu_ack <= push ? CPU_COUNT'(1) << ptr : '0;
      if (push) begin
        captured[ptr] <= 1'b1;
        collected <= collected + 1'b1;
      end
      if (state == SCAN && !(hit && full)) ptr <= ptr == IDX_WIDTH'(CPU_COUNT - 1) ? '0 : ptr + 1'b1;
    end
  md5_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .flush(clear),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign out_valid = !empty;
  assign out_index = out_valid ? IDX_WIDTH'(head.idx) : '0;
  assign out_md5 = out_valid ? HASH_WIDTH'(head.md5) : '0;
  assign all_done = state == DONE;
`ifdef MD5_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stall_cnt <= '0;
      timeout <= 1'b0;
    end else if (clear || push) begin
      stall_cnt <= '0;
      timeout <= timeout && !clear;
    end else if (state == SCAN && stall_cnt != TW'(TIMEOUT_CYCLES)) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_md5_result_collector.sv
// tb_md5_result_collector: table-driven, directed and randomized checks of md5_result_collector
module tb_md5_result_collector;
  localparam int N = 4, HW = 32, DEPTH = 2, TO = 16;
`ifdef MD5_COLLECT_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [N-1:0] cpu_done = '0;
  logic [HW-1:0] md5_tab [N];
  logic [HW-1:0] exp_md5 [N];
  logic [N*HW-1:0] cpu_md5;
  logic [N-1:0] cpu_ack;
  logic out_valid, all_done, timeout;
  logic [1:0] out_index;
  logic [HW-1:0] out_md5;
  logic [2:0] collected;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < N; g++) begin : g_md5
    assign cpu_md5[g*HW +: HW] = md5_tab[g];
  end
  md5_result_collector #(.CPU_COUNT(N), .HASH_WIDTH(HW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .cpu_done(cpu_done), .cpu_md5(cpu_md5),
    .cpu_ack(cpu_ack), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_md5(out_md5), .collected(collected), .all_done(all_done), .timeout(timeout)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  typedef struct { int idx; logic [HW-1:0] md5; int t; } rec_t;
  rec_t got[$];
  int ack_q[$];
  rec_t r;
  logic pv = 1'b0, pr = 1'b0, pc = 1'b0;
  logic [1:0] pi = '0;
  logic [HW-1:0] pm = '0;
  logic [N-1:0] pa = '0;
  // Stream/ack monitor: samples mid-low-phase, after inputs settle and before the next rising edge
  always begin
    @(negedge clock);
    #3;
    cyc++;
    if (reset_n) begin
      if (cpu_ack != '0) begin
        chk("ack_onehot", 64'($onehot(cpu_ack)), 1);
        chk("ack_one_cycle", 64'(cpu_ack & pa), 0);
        for (int i = 0; i < N; i++) if (cpu_ack[i]) ack_q.push_back(i);
      end
      if (pv && !pr && !pc) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_index", 64'(out_index), 64'(pi));
        chk("hold_md5", 64'(out_md5), 64'(pm));
      end
      if (out_valid && out_ready) begin
        r.idx = int'(out_index);
        r.md5 = out_md5;
        r.t = cyc;
        got.push_back(r);
      end
    end
    pv = out_valid; pr = out_ready; pc = clear; pi = out_index; pm = out_md5; pa = cpu_ack;
  end
  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    got.delete();
    ack_q.delete();
  endtask
  task automatic wait_recs(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("record_count", 64'(got.size()), 64'(n));
  endtask
  task automatic chk_order(input int e[N]);
    for (int i = 0; i < N && i < got.size(); i++) begin
      chk("order_idx", 64'(got[i].idx), 64'(e[i]));
      chk("order_md5", 64'(got[i].md5), 64'(exp_md5[e[i]]));
    end
  endtask
  task automatic chk_set();
    bit seen [N];
    chk("ack_count", 64'(ack_q.size()), 64'(N));
    foreach (got[i]) begin
      chk("rec_unique", 64'(seen[got[i].idx]), 0);
      seen[got[i].idx] = 1'b1;
      chk("rec_md5", 64'(got[i].md5), 64'(exp_md5[got[i].idx]));
      if (i < ack_q.size()) chk("rec_capture_order", 64'(got[i].idx), 64'(ack_q[i]));
    end
  endtask
  task automatic chk_end();
    repeat (3) @(negedge clock);
    chk("end_collected", 64'(collected), 64'(N));
    chk("end_all_done", 64'(all_done), 1);
    chk("end_valid", 64'(out_valid), 0);
  endtask
  typedef struct packed { logic v; logic [1:0] idx; logic [N-1:0] ack; logic [2:0] coll; logic done; } vec_t;
  initial begin
    vec_t tab [8];
    int rise_cyc [N];
    int rise [N];
    logic [HW-1:0] old0;
    tab = '{'{1'b0, 2'd0, 4'h0, 3'd0, 1'b0}, '{1'b1, 2'd0, 4'h1, 3'd1, 1'b0},
            '{1'b1, 2'd1, 4'h2, 3'd2, 1'b0}, '{1'b1, 2'd2, 4'h4, 3'd3, 1'b0},
            '{1'b1, 2'd3, 4'h8, 3'd4, 1'b0}, '{1'b0, 2'd0, 4'h0, 3'd4, 1'b0},
            '{1'b0, 2'd0, 4'h0, 3'd4, 1'b1}, '{1'b0, 2'd0, 4'h0, 3'd4, 1'b1}};
    for (int i = 0; i < N; i++) begin
      md5_tab[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
      exp_md5[i] = md5_tab[i];
    end
    cpu_done = '1;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ack", 64'(cpu_ack), 0);
    chk("rst_collected", 64'(collected), 0);
    chk("rst_all_done", 64'(all_done), 0);
    chk("rst_timeout", 64'(timeout), 0);
    chk("rst_index", 64'(out_index), 0);
    chk("rst_md5", 64'(out_md5), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("tab%0d_valid", i), 64'(out_valid), 64'(tab[i].v));
      chk($sformatf("tab%0d_index", i), 64'(out_index), 64'(tab[i].idx));
      chk($sformatf("tab%0d_md5", i), 64'(out_md5), tab[i].v ? 64'(exp_md5[tab[i].idx]) : 64'd0);
      chk($sformatf("tab%0d_ack", i), 64'(cpu_ack), 64'(tab[i].ack));
      chk($sformatf("tab%0d_collected", i), 64'(collected), 64'(tab[i].coll));
      chk($sformatf("tab%0d_all_done", i), 64'(all_done), 64'(tab[i].done));
    end
    chk_order('{0, 1, 2, 3});
    // Back-pressure: two records fill the FIFO and the scanner stalls at CPU 2
    out_ready = 1'b0;
    do_clear();
    repeat (8) @(negedge clock);
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_index", 64'(out_index), 0);
    chk("bp_collected", 64'(collected), 2);
    chk("bp_acks", 64'(ack_q.size()), 2);
    chk("bp_all_done", 64'(all_done), 0);
    out_ready = 1'b1;
    wait_recs(N, 40);
    chk_order('{0, 1, 2, 3});
    chk_end();
    // Late done on CPU 1 is picked up on the second lap
    cpu_done = 4'b1101;
    do_clear();
    repeat (2) @(negedge clock);
    cpu_done[1] = 1'b1;
    wait_recs(N, 40);
    chk_order('{0, 2, 3, 1});
    chk_end();
    // CPU 0 re-reset with a new hash after capture yields no second record
    cpu_done = 4'b0001;
    do_clear();
    repeat (6) @(negedge clock);
    chk("rerun_collected1", 64'(collected), 1);
    old0 = md5_tab[0];
    cpu_done[0] = 1'b0;
    md5_tab[0] = ~old0;
    repeat (2) @(negedge clock);
    cpu_done[0] = 1'b1;
    repeat (10) @(negedge clock);
    chk("rerun_collected2", 64'(collected), 1);
    chk("rerun_records", 64'(got.size()), 1);
    cpu_done = '1;
    wait_recs(N, 40);
    chk("rerun_first_idx", 64'(got[0].idx), 0);
    chk_set();
    chk_end();
    md5_tab[0] = old0;
    // Clear mid-session with three collected and records still queued
    out_ready = 1'b0;
    cpu_done = 4'b0111;
    do_clear();
    repeat (6) @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_collected", 64'(collected), 3);
    chk("mid_valid", 64'(out_valid), 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_valid", 64'(out_valid), 0);
    chk("clr_collected", 64'(collected), 0);
    chk("clr_ack", 64'(cpu_ack), 0);
    got.delete();
    ack_q.delete();
    cpu_done = '1;
    out_ready = 1'b1;
    wait_recs(N, 40);
    chk_set();
    chk_end();
    // CPU 3 never finishes: stall timer expires on the 16th idle scan cycle
    cpu_done = 4'b0111;
    do_clear();
    repeat (18) @(negedge clock);
    chk("to_before", 64'(timeout), 0);
    @(negedge clock);
    chk("to_after", 64'(timeout), 64'(TO_EXP));
    chk("to_all_done", 64'(all_done), 0);
    chk("to_collected", 64'(collected), 3);
    // Randomized sessions: random hashes, done arrival times and sink readiness
    for (int s = 0; s < 3; s++) begin
      cpu_done = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
        md5_tab[i] = $urandom;
        exp_md5[i] = md5_tab[i];
        rise[i] = $urandom_range(0, 20);
      end
      do_clear();
      for (int k = 0; k < 80; k++) begin
        for (int i = 0; i < N; i++)
          if (k == rise[i]) begin
            cpu_done[i] = 1'b1;
            rise_cyc[i] = cyc;
          end
        out_ready = $urandom_range(0, 9) < 6;
        @(negedge clock);
      end
      out_ready = 1'b1;
      wait_recs(N, 40);
      chk_set();
      foreach (got[i]) chk("rnd_after_done", 64'(got[i].t > rise_cyc[got[i].idx]), 1);
      chk_end();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
